// File: rtl/led_mem_arbiter_if.sv
// led_mem_arbiter_if: the SPI write, strip-driver read and channel-RAM signals
// of led_mem_arbiter, bundled into one interface.
// The slave modport is the arbiter side. The master modport is the
// environment side: spi_memory, the strip drivers and the RAM.
// Build macro LED_MEM_ARB_ADDR_CHECK_EN adds the addr_err signal.
interface led_mem_arbiter_if #(
  parameter int NUM_PORTS     = 2,
  parameter int ADDRESS_WIDTH = 8
);
  logic                             wr_valid;
  logic [ADDRESS_WIDTH-1:0]         wr_addr;
  logic [7:0]                       wr_data;
  logic                             wr_overflow;
  logic [NUM_PORTS-1:0]             rd_req;
  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] rd_addr;
  logic [NUM_PORTS-1:0]             rd_rdy;
  logic [NUM_PORTS*8-1:0]           rd_data;
  logic [ADDRESS_WIDTH-1:0]         ram_addr;
  logic                             ram_we;
  logic [7:0]                       ram_wdata;
  logic [7:0]                       ram_rdata;
  logic                             busy;
`ifdef LED_MEM_ARB_ADDR_CHECK_EN
  logic                             addr_err;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_req, rd_addr, ram_rdata,
    input  wr_overflow, rd_rdy, rd_data, ram_addr, ram_we, ram_wdata, busy, addr_err
  );
  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_req, rd_addr, ram_rdata,
    output wr_overflow, rd_rdy, rd_data, ram_addr, ram_we, ram_wdata, busy, addr_err
  );
`else
  modport master (
    output wr_valid, wr_addr, wr_data, rd_req, rd_addr, ram_rdata,
    input  wr_overflow, rd_rdy, rd_data, ram_addr, ram_we, ram_wdata, busy
  );
  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_req, rd_addr, ram_rdata,
    output wr_overflow, rd_rdy, rd_data, ram_addr, ram_we, ram_wdata, busy
  );
`endif
endinterface

// File: rtl/led_mem_arbiter.sv
// led_mem_arbiter: shares one single-port synchronous channel RAM between the
// SPI write path and NUM_PORTS strip-driver read ports.
// - SPI writes are held in a one-deep buffer and take priority over reads.
// - Reads are granted round-robin over a four-phase req/rdy handshake.
// Optional build macro LED_MEM_ARB_ADDR_CHECK_EN range-checks addresses
// against NUM_CHANNELS and adds the addr_err pulse.
module led_mem_arbiter #(
  parameter int NUM_PORTS     = 2,
  parameter int ADDRESS_WIDTH = 8,
  parameter int NUM_CHANNELS  = 216
) (
  input logic              clk,
  input logic              resetn,
  led_mem_arbiter_if.slave bus
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] ARB        = 2'd0;
  localparam logic [1:0] RD_ISSUE   = 2'd1;
  localparam logic [1:0] RD_CAPTURE = 2'd2;

  // Reject configurations the port packing and range check cannot support.
  if (NUM_PORTS < 1 || NUM_PORTS > 8 || NUM_CHANNELS < 1 ||
      NUM_CHANNELS > (1 << ADDRESS_WIDTH)) begin : g_param_err
    $error("led_mem_arbiter: unsupported parameter combination");
  end

  logic [1:0]             r_state;
  logic [PW-1:0]          r_rr;
  logic [PW-1:0]          r_gnt;
  logic                   r_pend;
  logic [AW-1:0]          r_pend_addr;
  logic [7:0]             r_pend_data;
  logic                   r_overflow;
  logic [NUM_PORTS-1:0]   r_rdy;
  logic [NUM_PORTS*8-1:0] r_rd_data;
  logic [AW-1:0]          r_ram_addr;
  logic                   r_ram_we;
  logic [7:0]             r_ram_wdata;

  logic [NUM_PORTS-1:0]   w_elig;
  logic                   w_found;
  logic [PW-1:0]          w_gnt;
  int                     w_idx;
  logic [AW-1:0]          w_gnt_addr;
  logic                   w_consume;
  logic                   w_wr_take;
  logic                   w_wr_capture;

`ifdef LED_MEM_ARB_ADDR_CHECK_EN
  logic                   r_rd_bad;
  logic                   r_addr_err;
  logic                   w_wr_bad;
  logic                   w_rd_bad;

  // Out-of-range writes are discarded before they reach the buffer.
  assign w_wr_bad  = bus.wr_valid && (int'(bus.wr_addr) >= NUM_CHANNELS);
  assign w_wr_take = bus.wr_valid && !w_wr_bad;
  // Out-of-range read grants bypass the RAM entirely.
  assign w_rd_bad  = (r_state == ARB) && !r_pend && w_found &&
                     (int'(w_gnt_addr) >= NUM_CHANNELS);
  assign bus.addr_err = r_addr_err;
`else
  assign w_wr_take = bus.wr_valid;
`endif

  // A port may be granted only once its previous rdy has been released.
  assign w_elig = bus.rd_req & ~r_rdy;

  // Round-robin search: first eligible port at or above the rr pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = r_rr;
    w_idx   = 0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      w_idx = (int'(r_rr) + off) % NUM_PORTS;
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = PW'(w_idx);
      end
    end
  end

  assign w_gnt_addr = bus.rd_addr[int'(w_gnt)*AW +: AW];

  // The buffered write drains on every ARB cycle in which it is present, so a
  // new write may refill the buffer on that same edge.
  assign w_consume    = (r_state == ARB) && r_pend;
  assign w_wr_capture = w_wr_take && (!r_pend || w_consume);

  // Write-buffer control: pending flag and overflow pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pend     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_wr_take && !w_wr_capture;
      if (w_wr_capture)
        r_pend <= 1'b1;
      else if (w_consume)
        r_pend <= 1'b0;
    end
  end

  // Write-buffer payload; only meaningful while r_pend is set, so no reset.
  always_ff @(posedge clk) begin
    if (w_wr_capture) begin
      r_pend_addr <= bus.wr_addr;
      r_pend_data <= bus.wr_data;
    end
  end

  // Arbitration FSM, RAM port registers and per-port rdy/data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ARB;
      r_rr        <= '0;
      r_gnt       <= '0;
      r_rdy       <= '0;
      r_rd_data   <= '0;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
`ifdef LED_MEM_ARB_ADDR_CHECK_EN
      r_rd_bad    <= 1'b0;
      r_addr_err  <= 1'b0;
`endif
    end else begin
      r_ram_we <= 1'b0;
      // rdy drops on the first edge that sees its request released.
      r_rdy    <= r_rdy & bus.rd_req;
`ifdef LED_MEM_ARB_ADDR_CHECK_EN
      r_addr_err <= w_wr_bad | w_rd_bad;
`endif
      case (r_state)
        ARB: begin
          if (r_pend) begin
            r_ram_we    <= 1'b1;
            r_ram_addr  <= r_pend_addr;
            r_ram_wdata <= r_pend_data;
          end else if (w_found) begin
            r_gnt <= w_gnt;
`ifdef LED_MEM_ARB_ADDR_CHECK_EN
            r_rd_bad <= w_rd_bad;
            if (w_rd_bad) begin
              r_state <= RD_CAPTURE;
            end else begin
`else
            begin
`endif
              r_ram_addr <= w_gnt_addr;
              r_state    <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE: begin
          r_state <= RD_CAPTURE;
        end
        RD_CAPTURE: begin
`ifdef LED_MEM_ARB_ADDR_CHECK_EN
          r_rd_data[int'(r_gnt)*8 +: 8] <= r_rd_bad ? 8'h00 : bus.ram_rdata;
`else
          r_rd_data[int'(r_gnt)*8 +: 8] <= bus.ram_rdata;
`endif
          r_rdy[r_gnt] <= 1'b1;
          r_rr         <= (int'(r_gnt) == NUM_PORTS - 1) ? '0 : r_gnt + PW'(1);
          r_state      <= ARB;
        end
        default: begin
          r_state <= ARB;
        end
      endcase
    end
  end

  assign bus.wr_overflow = r_overflow;
  assign bus.rd_rdy      = r_rdy;
  assign bus.rd_data     = r_rd_data;
  assign bus.ram_addr    = r_ram_addr;
  assign bus.ram_we      = r_ram_we;
  assign bus.ram_wdata   = r_ram_wdata;
  assign bus.busy        = (r_state != ARB);

endmodule

// File: tb/tb_led_mem_arbiter.sv
// tb_led_mem_arbiter: directed and randomized bench for led_mem_arbiter with a
// behavioural RAM and a transaction-level reference model.
module tb_led_mem_arbiter;

  localparam int NP  = 2;
  localparam int AW  = 8;
  localparam int NCH = 216;

  logic clk;
  logic resetn;
  int   n_total = 0;
  int   n_bad   = 0;

  led_mem_arbiter_if #(.NUM_PORTS(NP), .ADDRESS_WIDTH(AW)) bus ();

  led_mem_arbiter #(.NUM_PORTS(NP), .ADDRESS_WIDTH(AW), .NUM_CHANNELS(NCH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port synchronous RAM (read-first).
  logic [7:0] ram [256];
  logic [7:0] ram_q;
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    ram_q <= ram[bus.ram_addr];
  end
  assign bus.ram_rdata = ram_q;

  // Reference model: expected RAM contents plus a transaction view of the arbiter.
  logic [7:0]    ref_mem [256];
  bit            m_pend;
  logic [7:0]    m_pend_a, m_pend_d;
  int            m_left;          // cycles until the in-flight read returns; 0 = arbitrating
  int            m_port;
  logic [7:0]    m_addr;
  bit            m_bad;
  int            m_rr;
  logic [NP-1:0] m_rdy;
  logic [7:0]    m_data [NP];
  bit            m_we, m_ovf, m_err;
  logic [7:0]    m_ram_addr, m_wdata;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_left = 0; m_port = 0; m_bad = 0; m_rr = 0;
    m_rdy = '0; m_we = 0; m_ovf = 0; m_err = 0;
    m_ram_addr = '0; m_wdata = '0;
    for (int p = 0; p < NP; p++) m_data[p] = '0;
  endtask

  function automatic bit addr_bad(input logic [7:0] a);
`ifdef LED_MEM_ARB_ADDR_CHECK_EN
    return int'(a) >= NCH;
`else
    return 1'b0 & a[0];
`endif
  endfunction

  task automatic model_step();
    logic [NP-1:0] elig;
    bit            arb, had_pend, found;
    logic [7:0]    oa, od, a;
    int            g;
    elig = bus.rd_req & ~m_rdy;
    arb = (m_left == 0);
    had_pend = m_pend; oa = m_pend_a; od = m_pend_d;
    m_we = 0; m_ovf = 0; m_err = 0;
    // write buffer: accept if empty or draining this edge, otherwise drop
    if (bus.wr_valid && addr_bad(bus.wr_addr)) begin
      m_err = 1;
      if (arb && had_pend) m_pend = 0;
    end else if (bus.wr_valid) begin
      if (!had_pend || arb) begin
        m_pend = 1; m_pend_a = bus.wr_addr; m_pend_d = bus.wr_data;
      end else m_ovf = 1;
    end else if (arb && had_pend) m_pend = 0;
    m_rdy = m_rdy & bus.rd_req;
    if (arb) begin
      if (had_pend) begin
        m_we = 1; m_ram_addr = oa; m_wdata = od; ref_mem[oa] = od;
      end else begin
        found = 0; g = 0;
        for (int off = 0; off < NP; off++)
          if (!found && elig[(m_rr + off) % NP]) begin found = 1; g = (m_rr + off) % NP; end
        if (found) begin
          a = bus.rd_addr[g*AW +: AW];
          m_port = g; m_addr = a; m_bad = addr_bad(a);
          if (m_bad) begin m_left = 1; m_err = 1; end
          else begin m_left = 2; m_ram_addr = a; end
        end
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_data[m_port] = m_bad ? 8'h00 : ref_mem[m_addr];
        m_rdy[m_port] = 1'b1;
        m_rr = (m_port + 1) % NP;
      end
    end
  endtask

  task automatic check_all();
    chk_eq("busy", bus.busy, m_left != 0);
    chk_eq("ram_we", bus.ram_we, m_we);
    chk_eq("ram_addr", bus.ram_addr, m_ram_addr);
    chk_eq("ram_wdata", bus.ram_wdata, m_wdata);
    chk_eq("wr_overflow", bus.wr_overflow, m_ovf);
    chk_eq("rd_rdy", bus.rd_rdy, m_rdy);
    for (int p = 0; p < NP; p++) chk_eq($sformatf("rd_data%0d", p), bus.rd_data[p*8 +: 8], m_data[p]);
`ifdef LED_MEM_ARB_ADDR_CHECK_EN
    chk_eq("addr_err", bus.addr_err, m_err);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (!resetn) model_reset(); else model_step();
    #1;
    check_all();
  endtask

  task automatic set_req(input int p, input logic v, input logic [7:0] a);
    bus.rd_req[p] = v;
    bus.rd_addr[p*AW +: AW] = a;
  endtask

  task automatic set_wr(input logic v, input logic [7:0] a, input logic [7:0] d);
    bus.wr_valid = v; bus.wr_addr = a; bus.wr_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int rq_ph [NP];

  initial begin
    resetn = 1'b0;
    set_wr(0, 8'h00, 8'h00);
    bus.rd_req = '0; bus.rd_addr = '0;
    for (int i = 0; i < 256; i++) begin ram[i] = 8'(i); ref_mem[i] = 8'(i); end
    model_reset();
    tick(); tick();
    chk_eq("rst_busy", bus.busy, 1'b0);
    chk_eq("rst_rdy", bus.rd_rdy, '0);
    resetn = 1'b1;
    tick(); tick();
    chk_eq("idle_busy", bus.busy, 1'b0);
    chk_eq("idle_we", bus.ram_we, 1'b0);

    // Write 0xA5 to 0x05, then read it back on port 0.
    set_wr(1, 8'h05, 8'hA5); tick();
    chk_eq("wr_we_capture", bus.ram_we, 1'b0);
    set_wr(0, 8'h00, 8'h00); tick();
    chk_eq("wr_we", bus.ram_we, 1'b1);
    chk_eq("wr_addr", bus.ram_addr, 8'h05);
    chk_eq("wr_wdata", bus.ram_wdata, 8'hA5);
    tick();
    chk_eq("wr_we_pulse", bus.ram_we, 1'b0);
    set_req(0, 1, 8'h05); tick();
    chk_eq("rd_rdy_k1", bus.rd_rdy[0], 1'b0);
    chk_eq("rd_busy_k1", bus.busy, 1'b1);
    tick();
    chk_eq("rd_rdy_k2", bus.rd_rdy[0], 1'b0);
    tick();
    chk_eq("rd_rdy_k3", bus.rd_rdy[0], 1'b1);
    chk_eq("rd_data_a5", bus.rd_data[7:0], 8'hA5);
    set_req(0, 0, 8'h05); tick();
    chk_eq("rd_rdy_fall", bus.rd_rdy[0], 1'b0);
    chk_eq("rd_data_hold", bus.rd_data[7:0], 8'hA5);

    // Pending write against a port-1 request: write first, read sees new data.
    set_wr(1, 8'h40, 8'h33); tick();
    set_wr(0, 8'h00, 8'h00); set_req(1, 1, 8'h40); tick();
    chk_eq("prio_we", bus.ram_we, 1'b1);
    chk_eq("prio_addr", bus.ram_addr, 8'h40);
    tick();
    chk_eq("prio_rd_busy", bus.busy, 1'b1);
    set_wr(1, 8'h41, 8'h77); tick();
    set_wr(1, 8'h42, 8'h88); tick();
    chk_eq("ovf_pulse", bus.wr_overflow, 1'b1);
    chk_eq("prio_rd_data", bus.rd_data[15:8], 8'h33);
    set_wr(0, 8'h00, 8'h00); set_req(1, 0, 8'h40); tick();
    chk_eq("ovf_clear", bus.wr_overflow, 1'b0);
    chk_eq("kept_we", bus.ram_we, 1'b1);
    chk_eq("kept_addr", bus.ram_addr, 8'h41);
    chk_eq("kept_wdata", bus.ram_wdata, 8'h77);

    // Both ports request; port 0 releases early (protocol violation).
    set_req(0, 1, 8'h10); set_req(1, 1, 8'h20); tick();
    set_req(0, 0, 8'h10); tick(); tick();
    chk_eq("viol_rdy_up", bus.rd_rdy[0], 1'b1);
    chk_eq("viol_data", bus.rd_data[7:0], 8'h10);
    tick();
    chk_eq("viol_rdy_down", bus.rd_rdy[0], 1'b0);
    chk_eq("next_grant_busy", bus.busy, 1'b1);
    tick(); tick();
    chk_eq("p1_rdy", bus.rd_rdy[1], 1'b1);
    chk_eq("p1_data", bus.rd_data[15:8], 8'h20);
    set_req(1, 0, 8'h20); tick();

    // Asynchronous reset in the middle of a read.
    set_req(0, 1, 8'h08); tick(); tick();
    #2 resetn = 1'b0;
    #1;
    chk_eq("arst_rdy", bus.rd_rdy, '0);
    chk_eq("arst_we", bus.ram_we, 1'b0);
    chk_eq("arst_busy", bus.busy, 1'b0);
    chk_eq("arst_data", bus.rd_data, '0);
    model_reset();
    set_req(0, 0, 8'h08);
    tick();
    resetn = 1'b1;
    tick();

`ifdef LED_MEM_ARB_ADDR_CHECK_EN
    set_req(0, 1, 8'd216); tick();
    chk_eq("bad_rd_err", bus.addr_err, 1'b1);
    tick();
    chk_eq("bad_rd_rdy", bus.rd_rdy[0], 1'b1);
    chk_eq("bad_rd_data", bus.rd_data[7:0], 8'h00);
    set_req(0, 0, 8'd216); set_wr(1, 8'd250, 8'h5A); tick();
    chk_eq("bad_wr_err", bus.addr_err, 1'b1);
    set_wr(0, 8'h00, 8'h00); tick();
    chk_eq("bad_wr_we", bus.ram_we, 1'b0);
`endif

    // Randomized traffic: four-phase requesters plus random SPI writes.
    for (int p = 0; p < NP; p++) rq_ph[p] = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 4) == 0)
        set_wr(1, ($urandom_range(0, 7) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 31)),
               8'($urandom));
      else
        set_wr(0, 8'h00, 8'h00);
      for (int p = 0; p < NP; p++) begin
        case (rq_ph[p])
          0: if ($urandom_range(0, 2) == 0) begin
               set_req(p, 1, ($urandom_range(0, 7) == 0) ? 8'($urandom_range(200, 255))
                                                         : 8'($urandom_range(0, 31)));
               rq_ph[p] = 1;
             end
          1: if (bus.rd_rdy[p] || $urandom_range(0, 59) == 0) begin
               bus.rd_req[p] = 1'b0;
               rq_ph[p] = 2;
             end
          default: if (!bus.rd_rdy[p]) rq_ph[p] = 0;
        endcase
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
